decode_stage: RTL and testbench

- ID stage of the 5-stage pipeline. Consumes the IF/ID latch outputs (instruction word plus fetch PC).
- Reads a 32x32 register file and decodes a MIPS-subset opcode into control bits.
- Detects load-use hazards and registers the result into the ID/EX latch.
- Accepts the WB write port and the EX/MEM redirect, which flushes the latch.

---
 rtl/decode_stage.sv | 119 +++++++++++
 tb/tb_decode_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: register file, opcode decode, load-use hazard, ID/EX latch.
// Optional macro DECODE_WB_BYPASS_EN enables same-cycle WB write-through on the read ports.
module decode_stage #(
    parameter int NUM_REGS       = 32,
    parameter bit ILLEGAL_IS_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_npc,
    input  logic        ex_mem_pc_src,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [8:0]  id_ex_ctrl,
    output logic        id_ex_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // ctrl bit positions: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
    localparam int CTRL_MEM_READ = 4;

    logic [31:0] regs [NUM_REGS];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [8:0]  ctrl;
    logic        illegal;

    assign opcode  = if_id_instr[31:26];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign imm_ext = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

    always_comb begin
        ctrl    = 9'b0;
        illegal = 1'b0;
        unique case (opcode)
            OP_RTYPE: ctrl = 9'b1_0_0_1_0_0_0_10;
            OP_LW:    ctrl = 9'b0_1_1_1_1_0_0_00;
            OP_SW:    ctrl = 9'b0_1_0_0_0_1_0_00;
            OP_BEQ:   ctrl = 9'b0_0_0_0_0_0_1_01;
            default:  illegal = (ILLEGAL_IS_NOP == 1'b0);
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    // Write-through: a WB write in this cycle is visible to the read ports immediately.
    assign rs_data = (rs == 5'd0) ? 32'd0 :
                     (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) ? wb_data : regs[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 :
                     (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rt)) ? wb_data : regs[rt];
`else
    assign rs_data = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 : regs[rt];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_reg_write && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Load-use: the load in ID/EX produces its value too late for the instruction now in ID.
    assign stall = id_ex_ctrl[CTRL_MEM_READ] && (id_ex_rt != 5'd0) &&
                   ((id_ex_rt == rs) || (id_ex_rt == rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_npc     <= 32'd0;
            id_ex_rs_data <= 32'd0;
            id_ex_rt_data <= 32'd0;
            id_ex_imm     <= 32'd0;
            id_ex_rs      <= 5'd0;
            id_ex_rt      <= 5'd0;
            id_ex_rd      <= 5'd0;
            id_ex_ctrl    <= 9'd0;
            id_ex_illegal <= 1'b0;
        end else begin
            id_ex_npc     <= if_id_npc;
            id_ex_rs_data <= rs_data;
            id_ex_rt_data <= rt_data;
            id_ex_imm     <= imm_ext;
            id_ex_rs      <= rs;
            id_ex_rt      <= rt;
            id_ex_rd      <= rd;
            if (ex_mem_pc_src || stall) begin
                id_ex_ctrl    <= 9'd0;
                id_ex_illegal <= 1'b0;
            end else begin
                id_ex_ctrl    <= ctrl;
                id_ex_illegal <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with directed vectors.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_id_instr = 32'd0;
    logic [31:0] if_id_npc = 32'd0;
    logic        ex_mem_pc_src = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        stall;
    logic [31:0] id_ex_npc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [8:0]  id_ex_ctrl;
    logic        id_ex_illegal;

    decode_stage #(.NUM_REGS(32), .ILLEGAL_IS_NOP(1'b0)) dut (
        .clk(clk), .rst(rst),
        .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .ex_mem_pc_src(ex_mem_pc_src),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall),
        .id_ex_npc(id_ex_npc), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_illegal(id_ex_illegal)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] C_R   = 9'h122;
    localparam logic [8:0] C_LW  = 9'h0F0;
    localparam logic [8:0] C_BEQ = 9'h005;

    typedef struct {
        int          tag;
        logic        stall;
        logic        full;
        logic [8:0]  ctrl;
        logic        illegal;
        logic [31:0] npc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    bit   have_inflight = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    function automatic rec_t mk(input int tag, input logic st, input logic full, input logic [8:0] ctrl,
                                input logic ill, input logic [31:0] npc, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] imm,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rec_t r;
        r.tag = tag; r.stall = st; r.full = full; r.ctrl = ctrl; r.illegal = ill;
        r.npc = npc; r.rs_data = rsd; r.rt_data = rtd; r.imm = imm;
        r.rs = rs; r.rt = rt; r.rd = rd;
        return r;
    endfunction

    task automatic issue(input rec_t r, input logic [31:0] instr, input logic [31:0] npc, input logic flush,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        @(posedge clk);
        #2;
        if_id_instr = instr; if_id_npc = npc; ex_mem_pc_src = flush;
        wb_reg_write = we; wb_rd = wrd; wb_data = wd;
        q.push_back(r);
    endtask

    // Monitor: stall is checked while the vector is presented, the latch one edge later.
    always @(negedge clk) begin
        if (have_inflight) begin
            chk("ctrl", cur.tag, {23'd0, id_ex_ctrl}, {23'd0, cur.ctrl});
            chk("illegal", cur.tag, {31'd0, id_ex_illegal}, {31'd0, cur.illegal});
            if (cur.full) begin
                chk("npc", cur.tag, id_ex_npc, cur.npc);
                chk("rs_data", cur.tag, id_ex_rs_data, cur.rs_data);
                chk("rt_data", cur.tag, id_ex_rt_data, cur.rt_data);
                chk("imm", cur.tag, id_ex_imm, cur.imm);
                chk("rs", cur.tag, {27'd0, id_ex_rs}, {27'd0, cur.rs});
                chk("rt", cur.tag, {27'd0, id_ex_rt}, {27'd0, cur.rt});
                chk("rd", cur.tag, {27'd0, id_ex_rd}, {27'd0, cur.rd});
            end
            have_inflight = 0;
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk("stall", cur.tag, {31'd0, stall}, {31'd0, cur.stall});
            have_inflight = 1;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || have_inflight) && n < 10) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (q.size() > 0 || have_inflight) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
    endtask

    logic [31:0] bypass_exp;

    initial begin
`ifdef DECODE_WB_BYPASS_EN
        bypass_exp = 32'hCAFEF00D;
`else
        bypass_exp = 32'h00001234;
`endif
        #1 rst = 1'b1;
        #1;
        chk("rst_ctrl", 0, {23'd0, id_ex_ctrl}, 32'd0);
        chk("rst_npc", 0, id_ex_npc, 32'd0);
        chk("rst_stall", 0, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // write $5, then lw $6,-4($5), then dependent add
        issue(mk(1, 0, 1, C_R, 0, 32'h0C, 0, 0, 0, 0, 0, 0), 32'h0, 32'h0C, 0, 1, 5'd5, 32'h00001234);
        issue(mk(2, 0, 1, C_LW, 0, 32'h10, 32'h1234, 0, 32'hFFFFFFFC, 5, 6, 31),
              32'h8CA6FFFC, 32'h10, 0, 0, 0, 0);
        issue(mk(3, 1, 0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h00C53820, 32'h14, 0, 0, 0, 0);
        issue(mk(4, 0, 1, C_R, 0, 32'h14, 0, 32'h1234, 32'h3820, 6, 5, 7), 32'h00C53820, 32'h14, 0, 0, 0, 0);
        issue(mk(5, 0, 0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 0), 32'hACA60004, 32'h18, 1, 0, 0, 0);
        issue(mk(6, 0, 1, C_R, 0, 32'h1C, 0, 0, 0, 0, 0, 0), 32'h0, 32'h1C, 0, 1, 5'd0, 32'hDEADBEEF);
        issue(mk(7, 0, 1, C_R, 0, 32'h20, 0, 0, 32'h3820, 0, 0, 7), 32'h00003820, 32'h20, 0, 0, 0, 0);
        issue(mk(8, 0, 1, 9'd0, 1, 32'h24, 32'h1234, 0, 0, 5, 6, 0), 32'hFCA60000, 32'h24, 0, 0, 0, 0);
        issue(mk(9, 0, 1, C_R, 0, 32'h28, bypass_exp, 0, 0, 5, 0, 0),
              32'h00A00000, 32'h28, 0, 1, 5'd5, 32'hCAFEF00D);
        issue(mk(10, 0, 1, C_R, 0, 32'h2C, 32'hCAFEF00D, 0, 0, 5, 0, 0), 32'h00A00000, 32'h2C, 0, 0, 0, 0);
        issue(mk(11, 0, 1, C_BEQ, 0, 32'h30, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 5, 6, 31),
              32'h10A6FFFF, 32'h30, 0, 0, 0, 0);
        issue(mk(12, 0, 1, C_LW, 0, 32'h34, 32'hCAFEF00D, 0, 32'hFFFFFFFC, 5, 6, 31),
              32'h8CA6FFFC, 32'h34, 0, 0, 0, 0);
        issue(mk(13, 1, 0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h00C53820, 32'h38, 1, 0, 0, 0);
        issue(mk(14, 0, 1, C_R, 0, 32'h38, 0, 32'hCAFEF00D, 32'h3820, 6, 5, 7), 32'h00C53820, 32'h38, 0, 0, 0, 0);
        drain();

        // reset in the middle of a load-use stall, with a WB write pending
        @(posedge clk);
        #2 if_id_instr = 32'h8CA6FFFC; ex_mem_pc_src = 0; wb_reg_write = 0;
        @(posedge clk);
        #2 if_id_instr = 32'h00C53820; wb_reg_write = 1; wb_rd = 5'd9; wb_data = 32'h99;
        #1 chk("pre_rst_stall", 20, {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 20, {31'd0, stall}, 32'd0);
        chk("mid_rst_ctrl", 20, {23'd0, id_ex_ctrl}, 32'd0);
        chk("mid_rst_rs_data", 20, id_ex_rs_data, 32'd0);
        chk("mid_rst_imm", 20, id_ex_imm, 32'd0);
        chk("mid_rst_rt", 20, {27'd0, id_ex_rt}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0; wb_reg_write = 0;

        for (int i = 1; i < 32; i++) begin
            logic [4:0] ri;
            ri = i[4:0];
            issue(mk(100 + i, 0, 1, C_R, 0, i * 4, 0, 0, 0, ri, ri, 0),
                  {6'd0, ri, ri, 16'd0}, i * 4, 0, 0, 0, 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
